// File: rtl/astropix_spi_pkg.sv
// Shared types and constants for the AstroPix layer SPI responder.
// Imported by the responder top and its pin synchroniser.
package astropix_spi_pkg;

  localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hBC;
  localparam int MISO_BITS_PER_CLK = 2;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_FRAME,
    TX_ABORT
  } tx_state_t;

endpackage

// File: rtl/astropix_spi_pin_sync.sv
// Multi-stage synchroniser for asynchronous SPI pins with
// one-cycle rise/fall strobes taken from the synchronised level.
module spi_pin_sync
  import astropix_spi_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int STAGES = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= RST_VAL;
      end
      prev <= RST_VAL;
    end else begin
      chain[0] <= pins;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/astropix_spi_responder.sv
// Sensor-layer SPI responder: AXIS frame bytes out on 2-bit MISO,
// MOSI bytes in on an AXIS master, oversampled on a single clock.
module astropix_spi_responder
  import astropix_spi_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEFAULT,
  parameter bit         MSB_FIRST = 1'b0,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_csn,
  input  logic       spi_mosi,
  output logic [1:0] spi_miso,
  output logic       interruptn,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       stat_mosi_overflow,
  output logic       stat_frame_aborted
);

  localparam int SH = MISO_BITS_PER_CLK;

  logic [2:0] pin_lvl;
  logic [2:0] pin_rise;
  logic [2:0] pin_fall;

  // csn idles high so no phantom select is seen out of reset
  spi_pin_sync #(
    .WIDTH  (3),
    .STAGES (SYNC_STAGES),
    .RST_VAL(3'b010)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .pins ({spi_mosi, spi_csn, spi_clk}),
    .level(pin_lvl),
    .rise (pin_rise),
    .fall (pin_fall)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, pin_rise[2], pin_fall[2]};

  logic csn_low;
  logic clk_rise;
  logic clk_fall;
  logic csn_fall;
  logic csn_rise;
  logic mosi_bit;

  assign csn_low  = ~pin_lvl[1];
  assign clk_rise = pin_rise[0] & csn_low;
  assign clk_fall = pin_fall[0] & csn_low;
  assign csn_fall = pin_fall[1];
  assign csn_rise = pin_rise[1];
  assign mosi_bit = pin_lvl[2];

  logic [7:0] tx_sr;
  logic [7:0] tx_shift;
  logic [1:0] tx_cnt;
  logic       load;
  logic       pop;
  logic       abort;
  tx_state_t  state_q;
  tx_state_t  state_d;
  logic       resume_q;
  logic       resume_d;
  logic       frame_open;

  assign load  = csn_fall | (clk_fall & (tx_cnt == 2'd3));
  assign pop   = load & s_axis_tvalid & ~rst;
  assign abort = csn_rise &
                 ((state_q == TX_FRAME) | (tx_cnt != 2'd0));

  assign tx_shift = MSB_FIRST ?
                    {tx_sr[7-SH:0], {SH{1'b0}}} :
                    {{SH{1'b0}}, tx_sr[7:SH]};

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sr  <= '0;
      tx_cnt <= '0;
    end else if (load) begin
      tx_sr  <= pop ? s_axis_tdata : IDLE_BYTE;
      tx_cnt <= '0;
    end else if (clk_fall) begin
      tx_sr  <= tx_shift;
      tx_cnt <= tx_cnt + 2'd1;
    end else if (csn_rise) begin
      tx_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= TX_IDLE;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    unique case (state_q)
      TX_IDLE: begin
        if (abort) begin
          state_d  = TX_ABORT;
          resume_d = 1'b0;
        end else if (pop && !s_axis_tlast) begin
          state_d = TX_FRAME;
        end
      end
      TX_FRAME: begin
        if (abort) begin
          state_d  = TX_ABORT;
          resume_d = 1'b1;
        end else if (pop && s_axis_tlast) begin
          state_d = TX_IDLE;
        end
      end
      TX_ABORT: begin
        state_d = resume_q ? TX_FRAME : TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // an aborted mid-frame readout still counts as an open frame
  assign frame_open = (state_q == TX_FRAME) |
                      ((state_q == TX_ABORT) & resume_q);

  assign interruptn = rst | ~(s_axis_tvalid | frame_open);
  assign s_axis_tready = pop;
  assign stat_frame_aborted = (state_q == TX_ABORT);

  assign spi_miso = !csn_low ? 2'b00 :
                    MSB_FIRST ? tx_sr[7 -: SH] : tx_sr[SH-1:0];

  logic [7:0] rx_sr;
  logic [7:0] rx_byte;
  logic [2:0] rx_cnt;

  assign rx_byte = MSB_FIRST ? {rx_sr[6:0], mosi_bit} :
                               {mosi_bit, rx_sr[7:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sr              <= '0;
      rx_cnt             <= '0;
      m_axis_tdata       <= '0;
      m_axis_tvalid      <= 1'b0;
      stat_mosi_overflow <= 1'b0;
    end else begin
      stat_mosi_overflow <= 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (!csn_low) begin
        rx_cnt <= '0;
      end else if (clk_rise) begin
        rx_sr  <= rx_byte;
        rx_cnt <= rx_cnt + 3'd1;
        if (rx_cnt == 3'd7) begin
          // a held, unaccepted byte wins over the newer one
          if (m_axis_tvalid && !m_axis_tready) begin
            stat_mosi_overflow <= 1'b1;
          end else begin
            m_axis_tdata  <= rx_byte;
            m_axis_tvalid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_astropix_spi_responder.sv
// Directed bench for astropix_spi_responder: SPI master, AXIS
// source/sink and a byte-level model of what the chip should emit.
module tb_astropix_spi_responder;

  localparam int SPI_HALF = 8;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_clk;
  logic       spi_csn;
  logic       spi_mosi;
  logic [1:0] spi_miso;
  logic       interruptn;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tlast;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       stat_mosi_overflow;
  logic       stat_frame_aborted;

  astropix_spi_responder #(
    .IDLE_BYTE  (8'hBC),
    .MSB_FIRST  (1'b0),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .spi_clk           (spi_clk),
    .spi_csn           (spi_csn),
    .spi_mosi          (spi_mosi),
    .spi_miso          (spi_miso),
    .interruptn        (interruptn),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .stat_mosi_overflow(stat_mosi_overflow),
    .stat_frame_aborted(stat_frame_aborted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  int n_chk = 0;
  int n_fail = 0;
  beat_t src_q[$];
  logic [7:0] exp_m[$];
  logic [7:0] got_m[$];
  logic open_f = 1'b0;
  int pops = 0;
  int ovf_cnt = 0;
  int abt_cnt = 0;
  int csn_hi_cnt = 0;
  logic [7:0] rx_b [8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    src_q.push_back(b);
  endtask

  // AXIS source: a frame is open while the last byte taken lacked tlast
  initial begin : src_drv
    bit take;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tlast  = 1'b0;
    forever begin
      @(negedge clk);
      take = s_axis_tvalid && s_axis_tready;
      @(posedge clk);
      #1;
      if (take) begin
        open_f = !src_q[0].l;
        void'(src_q.pop_front());
        pops++;
      end
      if (src_q.size() > 0) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = src_q[0].d;
        s_axis_tlast  = src_q[0].l;
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        s_axis_tlast  = 1'b0;
      end
    end
  end

  initial begin : cmp
    forever begin
      @(negedge clk);
      csn_hi_cnt = spi_csn ? csn_hi_cnt + 1 : 0;
      if (!rst) begin
        chk("interruptn", {31'd0, interruptn},
            {31'd0, !(s_axis_tvalid || open_f)});
        if (csn_hi_cnt >= SYNC + 2)
          chk("miso_deselected", {30'd0, spi_miso}, 32'd0);
        if (m_axis_tvalid) begin
          if (exp_m.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL m_axis_unexpected: got 0x%0h, none expected",
                     m_axis_tdata);
          end else begin
            chk("m_axis_tdata", {24'd0, m_axis_tdata}, {24'd0, exp_m[0]});
            if (m_axis_tready) begin
              void'(exp_m.pop_front());
              got_m.push_back(m_axis_tdata);
            end
          end
        end
        if (stat_mosi_overflow) ovf_cnt++;
        if (stat_frame_aborted) abt_cnt++;
      end
    end
  end

  // one csn window of n spi_clk periods; MOSI bit j is mw[j]
  task automatic spi_xfer(input int n, input logic [31:0] mw,
                          input bit auto_exp);
    logic [7:0] lb [8];
    int loads;
    int exp_pop;
    int p0;
    int a0;
    logic exp_abt;
    loads = 1 + n / 4;
    for (int k = 0; k < 8; k++) begin
      lb[k] = (k < src_q.size() && k < loads) ? src_q[k].d : 8'hBC;
      rx_b[k] = 8'h00;
    end
    exp_pop = (src_q.size() < loads) ? src_q.size() : loads;
    p0 = pops;
    a0 = abt_cnt;
    @(posedge clk);
    #1;
    spi_csn  = 1'b0;
    spi_mosi = mw[0];
    repeat (6) @(posedge clk);
    #1;
    for (int j = 0; j < n; j++) begin
      spi_mosi = mw[j];
      repeat (SPI_HALF) @(posedge clk);
      #1;
      spi_clk = 1'b1;
      chk("miso_slot", {30'd0, spi_miso},
          32'((lb[j/4] >> (2 * (j % 4))) & 8'h03));
      rx_b[j/4][2*(j%4) +: 2] = spi_miso;
      if (auto_exp && (j % 8) == 7)
        exp_m.push_back(mw[j-7 +: 8]);
      repeat (SPI_HALF) @(posedge clk);
      #1;
      spi_clk = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;
    exp_abt = ((n % 4) != 0) || open_f;
    spi_csn  = 1'b1;
    spi_mosi = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("s_axis_pops", pops - p0, exp_pop);
    chk("frame_aborts", abt_cnt - a0, {31'd0, exp_abt});
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_m.size() > 0; i++)
      @(posedge clk);
    chk("m_axis_drain", exp_m.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int o0;
    rst = 1'b1;
    spi_clk = 1'b0;
    spi_csn = 1'b1;
    spi_mosi = 1'b0;
    m_axis_tready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_miso", {30'd0, spi_miso}, 32'd0);
    chk("rst_interruptn", {31'd0, interruptn}, 32'd1);
    chk("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_m_tdata", {24'd0, m_axis_tdata}, 32'd0);
    chk("rst_ovf", {31'd0, stat_mosi_overflow}, 32'd0);
    chk("rst_abort", {31'd0, stat_frame_aborted}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // idle readout
    spi_xfer(16, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++)
      chk("idle_byte", {24'd0, rx_b[k]}, 32'hBC);
    wait_drain();

    // frame send
    push(8'h21, 1'b0);
    push(8'h05, 1'b0);
    push(8'hA7, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("irq_after_push", {31'd0, interruptn}, 32'd0);
    spi_xfer(16, 32'h0, 1'b1);
    chk("frame_b0", {24'd0, rx_b[0]}, 32'h21);
    chk("frame_b1", {24'd0, rx_b[1]}, 32'h05);
    chk("frame_b2", {24'd0, rx_b[2]}, 32'hA7);
    chk("frame_b3", {24'd0, rx_b[3]}, 32'hBC);
    chk("irq_after_last", {31'd0, interruptn}, 32'd1);
    wait_drain();

    // MOSI capture
    got_m.delete();
    spi_xfer(16, 32'h0000C33C, 1'b1);
    wait_drain();
    chk("mosi_count", got_m.size(), 2);
    if (got_m.size() == 2) begin
      chk("mosi_b0", {24'd0, got_m[0]}, 32'h3C);
      chk("mosi_b1", {24'd0, got_m[1]}, 32'hC3);
    end

    // MOSI overflow
    m_axis_tready = 1'b0;
    o0 = ovf_cnt;
    exp_m.push_back(8'h11);
    spi_xfer(16, 32'h00002211, 1'b0);
    chk("ovf_hold_valid", {31'd0, m_axis_tvalid}, 32'd1);
    chk("ovf_hold_data", {24'd0, m_axis_tdata}, 32'h11);
    chk("ovf_pulses", ovf_cnt - o0, 1);
    m_axis_tready = 1'b1;
    wait_drain();

    // csn high clears a partial MOSI byte
    got_m.delete();
    spi_xfer(4, 32'h0000000F, 1'b1);
    spi_xfer(8, 32'h0000005A, 1'b1);
    wait_drain();
    chk("partial_dropped", got_m.size(), 1);
    if (got_m.size() == 1)
      chk("after_partial", {24'd0, got_m[0]}, 32'h5A);

    // abort mid-byte, resume with the third byte
    push(8'h31, 1'b0);
    push(8'h32, 1'b0);
    push(8'h33, 1'b0);
    push(8'h34, 1'b1);
    spi_xfer(6, 32'h0, 1'b1);
    chk("abort_b0", {24'd0, rx_b[0]}, 32'h31);
    chk("abort_src_left", src_q.size(), 2);
    spi_xfer(16, 32'h0, 1'b1);
    chk("resume_b0", {24'd0, rx_b[0]}, 32'h33);
    chk("resume_b1", {24'd0, rx_b[1]}, 32'h34);
    chk("resume_b2", {24'd0, rx_b[2]}, 32'hBC);
    wait_drain();

    // underrun inside an open frame
    push(8'h10, 1'b0);
    spi_xfer(8, 32'h0, 1'b1);
    chk("underrun_b0", {24'd0, rx_b[0]}, 32'h10);
    chk("underrun_b1", {24'd0, rx_b[1]}, 32'hBC);
    @(negedge clk);
    chk("underrun_irq", {31'd0, interruptn}, 32'd0);
    push(8'h99, 1'b1);
    spi_xfer(4, 32'h0, 1'b1);
    chk("close_b0", {24'd0, rx_b[0]}, 32'h99);
    @(negedge clk);
    chk("close_irq", {31'd0, interruptn}, 32'd1);
    wait_drain();

    repeat (10) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
